// File: rtl/config_frame_writer_if.sv
// Byte-in / register-write-out bundle for config_frame_writer.
// The slave modport is the writer's view; master is the side that feeds bytes
// and observes the register bank port.
interface config_frame_writer_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        WREN;
  logic [1:0]  ABUS;
  logic [15:0] DBUS;
  logic        WR_DONE;
  logic        FRM_ERR;
  logic [7:0]  ERR_CNT;

  modport slave (
    input  RX_DATA, RX_VALID,
    output WREN, ABUS, DBUS, WR_DONE, FRM_ERR, ERR_CNT
  );

  modport master (
    output RX_DATA, RX_VALID,
    input  WREN, ABUS, DBUS, WR_DONE, FRM_ERR, ERR_CNT
  );
endinterface

// File: rtl/config_frame_writer.sv
// Parses 4-byte configuration frames {header, data_hi, data_lo, xor} from a
// byte stream and issues one register write per valid frame. Rejected frames
// (bad header, bad checksum, inter-byte timeout) pulse FRM_ERR and bump a
// saturating error counter.
module config_frame_writer #(
  parameter int unsigned TIMEOUT = 1000,
  parameter logic [5:0]  HDR     = 6'b101000
) (
  input logic                   CLK,
  input logic                   RST,
  config_frame_writer_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_HI  = 3'd1,
    GET_LO  = 3'd2,
    GET_CHK = 3'd3,
    WRITE   = 3'd4
  } state_e;

  state_e          state_q;
  logic [1:0]      addr_q;
  logic [7:0]      hi_q;
  logic [7:0]      lo_q;
  logic [CntW-1:0] idle_cnt_q;
  logic            wren_q;
  logic            wr_done_q;
  logic            frm_err_q;
  logic [1:0]      abus_q;
  logic [15:0]     dbus_q;
  logic [7:0]      err_cnt_q;

  logic hdr_ok;
  logic chk_ok;
  logic in_frame;
  logic timeout;
  logic err_set;

  // Byte classification and error detection for the current cycle.
  always_comb begin
    hdr_ok   = (bus.RX_DATA[7:2] == HDR);
    chk_ok   = (bus.RX_DATA == ({HDR, addr_q} ^ hi_q ^ lo_q));
    in_frame = (state_q == GET_HI) || (state_q == GET_LO) || (state_q == GET_CHK);
    // A byte in the expiry cycle wins over the timeout.
    timeout  = in_frame && !bus.RX_VALID && (idle_cnt_q == CntLast);
    err_set  = timeout ||
               (bus.RX_VALID && !hdr_ok && ((state_q == IDLE) || (state_q == WRITE))) ||
               (bus.RX_VALID && !chk_ok && (state_q == GET_CHK));
  end

  // Frame FSM with registered write/error outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      idle_cnt_q <= '0;
      wren_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      abus_q     <= '0;
      dbus_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      wren_q    <= 1'b0;
      wr_done_q <= (state_q == WRITE);
      frm_err_q <= err_set;
      if (err_set && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end

      unique case (state_q)
        // WRITE treats its byte as a header so back-to-back frames lose nothing.
        IDLE, WRITE: begin
          idle_cnt_q <= '0;
          state_q    <= IDLE;
          if (bus.RX_VALID && hdr_ok) begin
            addr_q  <= bus.RX_DATA[1:0];
            state_q <= GET_HI;
          end
        end
        GET_HI, GET_LO, GET_CHK: begin
          if (bus.RX_VALID) begin
            idle_cnt_q <= '0;
            if (state_q == GET_HI) begin
              hi_q    <= bus.RX_DATA;
              state_q <= GET_LO;
            end else if (state_q == GET_LO) begin
              lo_q    <= bus.RX_DATA;
              state_q <= GET_CHK;
            end else if (chk_ok) begin
              wren_q  <= 1'b1;
              abus_q  <= addr_q;
              dbus_q  <= {hi_q, lo_q};
              state_q <= WRITE;
            end else begin
              state_q <= IDLE;
            end
          end else if (timeout) begin
            idle_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: begin
          idle_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.WREN    = wren_q;
  assign bus.ABUS    = abus_q;
  assign bus.DBUS    = dbus_q;
  assign bus.WR_DONE = wr_done_q;
  assign bus.FRM_ERR = frm_err_q;
  assign bus.ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer with TIMEOUT = 8.
module tb_config_frame_writer;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  // Counts kept by the negedge monitor.
  int wren_pulses = 0;
  int err_pulses = 0;
  int done_pulses = 0;
  int overlap = 0;
  int repeats = 0;
  logic prev_wren = 1'b0, prev_done = 1'b0;

  config_frame_writer_if bus ();

  config_frame_writer #(
    .TIMEOUT(8),
    .HDR    (6'b101000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Observe outputs mid-cycle.
  always @(negedge CLK) begin
    if (bus.WREN) wren_pulses++;
    if (bus.FRM_ERR) err_pulses++;
    if (bus.WR_DONE) done_pulses++;
    if (bus.WREN && bus.FRM_ERR) overlap++;
    if ((bus.WREN && prev_wren) || (bus.WR_DONE && prev_done)) repeats++;
    prev_wren = bus.WREN;
    prev_done = bus.WR_DONE;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.RX_VALID = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.RX_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int w0, e0;

  initial begin
    RST = 1'b1;
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    cycles(3);
    check("rst_wren", bus.WREN, 0);
    check("rst_done", bus.WR_DONE, 0);
    check("rst_err", bus.FRM_ERR, 0);
    check("rst_abus", bus.ABUS, 0);
    check("rst_dbus", bus.DBUS, 0);
    check("rst_errcnt", bus.ERR_CNT, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Good frame, with exact write latency.
    send_byte(8'hA1); send_byte(8'h12); send_byte(8'h34);
    check("good_pre_wren", bus.WREN, 0);
    send_byte(8'h87);
    check("good_wren", bus.WREN, 1);
    check("good_abus", bus.ABUS, 2'b01);
    check("good_dbus", bus.DBUS, 16'h1234);
    check("good_done_early", bus.WR_DONE, 0);
    cycles(1);
    check("good_wren_off", bus.WREN, 0);
    check("good_done", bus.WR_DONE, 1);
    cycles(1);
    check("good_done_off", bus.WR_DONE, 0);
    check("good_errcnt", bus.ERR_CNT, 0);

    // Bad checksum: no write, bank outputs hold.
    w0 = wren_pulses;
    send_byte(8'hA2); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    check("badchk_err", bus.FRM_ERR, 1);
    check("badchk_wren", bus.WREN, 0);
    check("badchk_errcnt", bus.ERR_CNT, 1);
    cycles(2);
    check("badchk_err_off", bus.FRM_ERR, 0);
    check("badchk_abus", bus.ABUS, 2'b01);
    check("badchk_dbus", bus.DBUS, 16'h1234);
    check("badchk_nowrite", wren_pulses - w0, 0);

    // Bad header then a good frame.
    do_reset();
    send_byte(8'h55);
    check("badhdr_err", bus.FRM_ERR, 1);
    check("badhdr_errcnt", bus.ERR_CNT, 1);
    send_byte(8'hA3); send_byte(8'h00); send_byte(8'h10); send_byte(8'hB3);
    check("badhdr_wren", bus.WREN, 1);
    check("badhdr_abus", bus.ABUS, 2'b11);
    check("badhdr_dbus", bus.DBUS, 16'h0010);
    cycles(2);

    // Timeout after 8 idle cycles.
    send_byte(8'hA0);
    cycles(7);
    check("tmo_early", bus.FRM_ERR, 0);
    cycles(1);
    check("tmo_err", bus.FRM_ERR, 1);
    check("tmo_errcnt", bus.ERR_CNT, 2);
    send_byte(8'hA0); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hA0);
    check("tmo_next_wren", bus.WREN, 1);
    check("tmo_next_abus", bus.ABUS, 2'b00);
    check("tmo_next_dbus", bus.DBUS, 16'hFFFF);
    cycles(2);

    // Byte arriving in the expiry cycle wins.
    e0 = err_pulses;
    send_byte(8'hA0);
    cycles(7);
    send_byte(8'h12);
    check("tmo_race_err", bus.FRM_ERR, 0);
    send_byte(8'h34); send_byte(8'h86);
    check("tmo_race_wren", bus.WREN, 1);
    check("tmo_race_dbus", bus.DBUS, 16'h1234);
    cycles(2);
    check("tmo_race_noerr", err_pulses - e0, 0);

    // Back-to-back frames: second header lands in the WRITE cycle.
    do_reset();
    w0 = wren_pulses;
    send_byte(8'hA1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h87);
    check("b2b_first_wren", bus.WREN, 1);
    send_byte(8'hA2); send_byte(8'h56); send_byte(8'h78); send_byte(8'h8C);
    check("b2b_second_wren", bus.WREN, 1);
    check("b2b_abus", bus.ABUS, 2'b10);
    check("b2b_dbus", bus.DBUS, 16'h5678);
    cycles(2);
    check("b2b_count", wren_pulses - w0, 2);
    check("b2b_errcnt", bus.ERR_CNT, 0);

    // Reset coincident with checksum acceptance suppresses the write.
    send_byte(8'hA1); send_byte(8'h12); send_byte(8'h34);
    @(negedge CLK);
    bus.RX_DATA  = 8'h87;
    bus.RX_VALID = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    bus.RX_VALID = 1'b0;
    check("rst_chk_wren", bus.WREN, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset mid-frame: discarded silently, no later timeout.
    w0 = wren_pulses;
    e0 = err_pulses;
    send_byte(8'hA1); send_byte(8'h12);
    do_reset();
    cycles(12);
    check("midrst_nowrite", wren_pulses - w0, 0);
    check("midrst_noerr", err_pulses - e0, 0);

    // Saturating error counter.
    e0 = err_pulses;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h55);
      cycles(1);
    end
    cycles(1);
    check("sat_errcnt", bus.ERR_CNT, 255);
    check("sat_pulses", err_pulses - e0, 260);

    check("never_overlap", overlap, 0);
    check("never_repeat", repeats, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 1000, giving the maximum number of idle clock cycles allowed between bytes of one frame.
REQ-002 The block SHALL provide parameter HDR, default 6'b101000, which is the required value of header byte bits [7:2].
REQ-003 CLK  input  1  system clock; all logic SHALL act on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 RX_DATA  input  8  received byte from the serial receiver.
REQ-006 RX_VALID  input  1  one-cycle strobe; RX_DATA is valid in this cycle.
REQ-007 WREN  output  1  write strobe to the configuration register bank.
REQ-008 ABUS  output  2  register address (00 FWLEN, 01 SWLEN, 10 SERVICE, 11 RST_LMT).
REQ-009 DBUS  output  16  register write data.
REQ-010 WR_DONE  output  1  one-cycle pulse confirming a completed write.
REQ-011 FRM_ERR  output  1  one-cycle pulse reporting a rejected frame.
REQ-012 ERR_CNT  output  8  saturating count of rejected frames.

Function
REQ-013 A frame SHALL be 4 bytes: H = {HDR, addr[1:0]}; D1 = data[15:8]; D0 = data[7:0]; C = H ^ D1 ^ D0.
REQ-014 The FSM SHALL have states IDLE, GET_HI, GET_LO, GET_CHK and WRITE.
REQ-015 In IDLE, a byte with bits [7:2] == HDR SHALL latch addr and move the FSM to GET_HI.
REQ-016 In IDLE, a byte with bits [7:2] != HDR SHALL pulse FRM_ERR in the next cycle, and the FSM SHALL stay in IDLE.
REQ-017 In GET_HI, a byte SHALL latch data[15:8] and move the FSM to GET_LO.
REQ-018 In GET_LO, a byte SHALL latch data[7:0] and move the FSM to GET_CHK.
REQ-019 In GET_CHK, a byte equal to the running XOR SHALL move the FSM to WRITE.
REQ-020 In GET_CHK, a byte not equal to the running XOR SHALL pulse FRM_ERR in the next cycle, return the FSM to IDLE, and cause no write.
REQ-021 WRITE SHALL last exactly 1 cycle; during it, WREN = 1 and ABUS/DBUS carry the frame address and data.
REQ-022 If the checksum byte is accepted at edge t, WREN SHALL be high in cycle t+1, and WR_DONE SHALL pulse in cycle t+2.
REQ-023 ABUS and DBUS SHALL be registered and SHALL hold the last written values when WREN = 0; they SHALL change only on entry to WRITE.
REQ-024 A byte arriving during the WRITE cycle SHALL be evaluated as a header byte, as if the FSM were in IDLE, so back-to-back frames lose no byte.
REQ-025 The idle counter SHALL count cycles in GET_HI, GET_LO and GET_CHK without RX_VALID, and SHALL clear on each accepted byte and in IDLE.
REQ-026 When the idle counter reaches TIMEOUT, the block SHALL pulse FRM_ERR, return the FSM to IDLE, and discard the partial frame.
REQ-027 If RX_VALID and timeout expiry occur in the same cycle, the byte SHALL win and no error SHALL be raised.
REQ-028 ERR_CNT SHALL increment by 1 on every FRM_ERR pulse and SHALL saturate at 255.
REQ-029 WREN, WR_DONE and FRM_ERR SHALL never be high for more than one consecutive cycle per event.
REQ-030 WREN and FRM_ERR SHALL never be high in the same cycle.

Reset
REQ-031 On RST = 1 at a clock edge, the block SHALL reset: FSM = IDLE; WREN = 0; WR_DONE = 0; FRM_ERR = 0; ABUS = 0; DBUS = 0; ERR_CNT = 0; idle counter = 0; latched frame fields = 0.
REQ-032 RST SHALL take priority over RX_VALID.
REQ-033 A frame in progress at reset SHALL be discarded with no write and no FRM_ERR.
REQ-034 A WRITE cycle coincident with RST SHALL be suppressed (WREN = 0).

Verification
REQ-035 Good frame: bytes A1, 12, 34, 87 -> one WREN cycle with ABUS = 01, DBUS = 0x1234, then WR_DONE; ERR_CNT = 0.
REQ-036 Bad checksum: bytes A2, 00, 05, 00 -> no WREN, one FRM_ERR pulse, ERR_CNT = 1; ABUS/DBUS unchanged.
REQ-037 Bad header: byte 55 -> FRM_ERR, ERR_CNT = 1; then the frame A3, 00, 10, B3 -> write with ABUS = 11, DBUS = 0x0010.
REQ-038 Timeout, with TIMEOUT = 8: send A0, then wait 8 idle cycles -> FRM_ERR, FSM in IDLE; the next frame A0, FF, FF, A0 -> DBUS = 0xFFFF.
REQ-039 Back-to-back: header of the second frame arrives in the WRITE cycle of the first -> both frames written, 2 WREN pulses, ERR_CNT = 0.
REQ-040 Reset mid-frame: assert RST after A1, 12 -> no WREN, no FRM_ERR; 260 bad headers after reset -> ERR_CNT = 255.
